page_table_walker: RTL and testbench

- Hardware TLB-refill engine. It sits beside the data/instruction TLB and consumes that TLB's hit flag.
- On a user-mode miss it reads a single-level page table from memory, then drives the TLB write port (write, vaddr, paddr_new) to install the translation.
- An invalid page-table entry (PTE) raises a page fault instead.
- It stalls the pipeline stage that owns the access for the whole walk.

---
 rtl/page_table_walker_if.sv | 23 ++
 rtl/page_table_walker.sv | 152 +++++++++++++++
 tb/tb_page_table_walker.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/page_table_walker_if.sv
// PTE read port between the page table walker and the memory system.
// The walker is the master: it raises mem_req with a stable mem_addr and
// receives a single mem_ready pulse carrying mem_rdata.

`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef SUPERVISOR_MODE
`define SUPERVISOR_MODE 2'b01
`endif

interface page_table_walker_if #(
    parameter int PA_W  = 32,
    parameter int PTE_W = 32
);
    logic             mem_req;
    logic [PA_W-1:0]  mem_addr;
    logic             mem_ready;
    logic [PTE_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/page_table_walker.sv
// TLB refill engine: on a user-mode TLB miss it fetches the PTE from a
// single-level page table, then either installs the translation through the
// TLB write port or raises a one-cycle page fault. The owning pipeline stage
// is stalled through busy for the whole walk, including the miss cycle.

`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef SUPERVISOR_MODE
`define SUPERVISOR_MODE 2'b01
`endif

module page_table_walker #(
    parameter int VA_W      = 32,
    parameter int PA_W      = 32,
    parameter int PAGE_BITS = 12,
    parameter int PTE_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [`MODE_WIDTH-1:0] mode,
    input  logic                   access_valid,
    input  logic [VA_W-1:0]        vaddr,
    input  logic                   tlb_hit,
    input  logic [PA_W-1:0]        ptbr,
    input  logic                   flush,
    page_table_walker_if.master    mem,
    output logic                   tlb_write,
    output logic                   tlb_vaddr_sel,
    output logic [VA_W-1:0]        walk_vaddr,
    output logic [PA_W-1:0]        tlb_paddr_new,
    output logic                   busy,
    output logic                   page_fault,
    output logic [VA_W-1:0]        fault_vaddr
);

    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int PPN_W = PA_W - PAGE_BITS;

    typedef enum logic [2:0] {IDLE, REQ, FILL, FAULT, DRAIN} state_t;

    state_t           state;
    state_t           state_next;
    logic             miss;
    logic [VPN_W-1:0] vpn;
    logic [PA_W-1:0]  pte_addr;
    logic [PA_W-1:0]  mem_addr_q;
    logic             pte_valid;
    logic [PPN_W-1:0] pte_ppn;
    logic             unused_bits;

    assign miss      = access_valid && !tlb_hit && (mode != `SUPERVISOR_MODE) && !flush;
    assign vpn       = vaddr[VA_W-1:PAGE_BITS];
    // PTEs are 4 bytes; the sum wraps modulo 2^PA_W.
    assign pte_addr  = ptbr + PA_W'({vpn, 2'b00});
    assign pte_valid = mem.mem_rdata[PTE_W-1];
    assign pte_ppn   = mem.mem_rdata[PPN_W-1:0];
    assign mem.mem_addr = mem_addr_q;

    // Page offset and reserved PTE bits play no part in the walk.
    assign unused_bits = ^{vaddr[PAGE_BITS-1:0], mem.mem_rdata[PTE_W-2:PPN_W]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore/Mealy outputs; busy includes the miss cycle in IDLE.
    always_comb begin
        state_next    = state;
        mem.mem_req   = 1'b0;
        tlb_write     = 1'b0;
        tlb_vaddr_sel = 1'b0;
        busy          = 1'b0;
        page_fault    = 1'b0;
        case (state)
            IDLE: begin
                busy = miss;
                if (miss) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem.mem_req = 1'b1;
                busy        = 1'b1;
                if (mem.mem_ready) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else if (pte_valid) begin
                        state_next = FILL;
                    end else begin
                        state_next = FAULT;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            FILL: begin
                tlb_write     = 1'b1;
                tlb_vaddr_sel = 1'b1;
                busy          = 1'b1;
                state_next    = IDLE;
            end
            FAULT: begin
                page_fault = 1'b1;
                busy       = 1'b1;
                state_next = IDLE;
            end
            DRAIN: begin
                busy = 1'b1;
                if (mem.mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Walk datapath: capture miss address and PTE address, then the PTE outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            walk_vaddr    <= '0;
            mem_addr_q    <= '0;
            tlb_paddr_new <= '0;
            fault_vaddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss) begin
                        walk_vaddr <= vaddr;
                        mem_addr_q <= pte_addr;
                    end
                end
                REQ: begin
                    if (mem.mem_ready && !flush) begin
                        if (pte_valid) begin
                            tlb_paddr_new <= {pte_ppn, {PAGE_BITS{1'b0}}};
                        end else begin
                            fault_vaddr <= walk_vaddr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker: refill, fault, filtering, flush,
// address wrap and reset mid-walk, with hand-computed expected values.

`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef SUPERVISOR_MODE
`define SUPERVISOR_MODE 2'b01
`endif

module tb_page_table_walker;

    localparam logic [`MODE_WIDTH-1:0] USER = 2'b00;
    localparam logic [`MODE_WIDTH-1:0] SUPV = `SUPERVISOR_MODE;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [`MODE_WIDTH-1:0] mode;
    logic                   access_valid;
    logic [31:0]            vaddr;
    logic                   tlb_hit;
    logic [31:0]            ptbr;
    logic                   flush;
    logic                   tlb_write;
    logic                   tlb_vaddr_sel;
    logic [31:0]            walk_vaddr;
    logic [31:0]            tlb_paddr_new;
    logic                   busy;
    logic                   page_fault;
    logic [31:0]            fault_vaddr;

    int total = 0;
    int bad   = 0;

    page_table_walker_if #(.PA_W(32), .PTE_W(32)) mem_if ();

    page_table_walker #(
        .VA_W(32), .PA_W(32), .PAGE_BITS(12), .PTE_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .access_valid(access_valid),
        .vaddr(vaddr),
        .tlb_hit(tlb_hit),
        .ptbr(ptbr),
        .flush(flush),
        .mem(mem_if),
        .tlb_write(tlb_write),
        .tlb_vaddr_sel(tlb_vaddr_sel),
        .walk_vaddr(walk_vaddr),
        .tlb_paddr_new(tlb_paddr_new),
        .busy(busy),
        .page_fault(page_fault),
        .fault_vaddr(fault_vaddr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after settling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_req"}, 32'(mem_if.mem_req), 32'd0);
        check({tag, "_wr"}, 32'(tlb_write), 32'd0);
        check({tag, "_pf"}, 32'(page_fault), 32'd0);
    endtask

    logic [`MODE_WIDTH-1:0] f_mode  [4];
    logic                   f_hit   [4];
    logic                   f_valid [4];
    logic                   f_flush [4];

    initial begin
        reset = 1'b1; mode = USER; access_valid = 1'b0; vaddr = '0; tlb_hit = 1'b0;
        ptbr = '0; flush = 1'b0; mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
        tick(); tick();

        // Reset state
        settle();
        check_quiet("rst");
        check("rst_sel", 32'(tlb_vaddr_sel), 32'd0);
        check("rst_addr", mem_if.mem_addr, 32'h0);
        check("rst_wva", walk_vaddr, 32'h0);
        check("rst_pa", tlb_paddr_new, 32'h0);
        check("rst_fva", fault_vaddr, 32'h0);
        reset = 1'b0;
        tick();

        // Basic refill
        ptbr = 32'h0001_0000; vaddr = 32'h0000_5ABC; tlb_hit = 1'b0; access_valid = 1'b1;
        settle();
        check("ref_miss_busy", 32'(busy), 32'd1);
        check("ref_miss_req", 32'(mem_if.mem_req), 32'd0);
        tick();
        check("ref_req1", 32'(mem_if.mem_req), 32'd1);
        check("ref_addr", mem_if.mem_addr, 32'h0001_0014);
        check("ref_req1_busy", 32'(busy), 32'd1);
        tick();
        check("ref_req2", 32'(mem_if.mem_req), 32'd1);
        tick();
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h8000_0123;
        settle();
        check("ref_req3", 32'(mem_if.mem_req), 32'd1);
        check("ref_req3_addr", mem_if.mem_addr, 32'h0001_0014);
        tick();
        mem_if.mem_ready = 1'b0; tlb_hit = 1'b1;
        settle();
        check("ref_fill_wr", 32'(tlb_write), 32'd1);
        check("ref_fill_sel", 32'(tlb_vaddr_sel), 32'd1);
        check("ref_fill_busy", 32'(busy), 32'd1);
        check("ref_fill_req", 32'(mem_if.mem_req), 32'd0);
        check("ref_wva", walk_vaddr, 32'h0000_5ABC);
        check("ref_pa", tlb_paddr_new, 32'h0012_3000);
        tick();
        settle();
        check_quiet("ref_retry");
        check("ref_retry_sel", 32'(tlb_vaddr_sel), 32'd0);
        access_valid = 1'b0; tlb_hit = 1'b0;
        tick();

        // Page fault
        access_valid = 1'b1; vaddr = 32'h0000_5ABC;
        tick();
        check("pf_req", 32'(mem_if.mem_req), 32'd1);
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h0000_0123;
        tick();
        mem_if.mem_ready = 1'b0; access_valid = 1'b0;
        settle();
        check("pf_pulse", 32'(page_fault), 32'd1);
        check("pf_wr", 32'(tlb_write), 32'd0);
        check("pf_busy", 32'(busy), 32'd1);
        check("pf_fva", fault_vaddr, 32'h0000_5ABC);
        tick();
        check_quiet("pf_after");
        check("pf_fva_hold", fault_vaddr, 32'h0000_5ABC);
        check("pf_pa_hold", tlb_paddr_new, 32'h0012_3000);

        // Supervisor / hit / no-access / flush filtering
        f_mode  = '{SUPV, USER, USER, USER};
        f_hit   = '{1'b0, 1'b1, 1'b0, 1'b0};
        f_valid = '{1'b1, 1'b1, 1'b0, 1'b1};
        f_flush = '{1'b0, 1'b0, 1'b0, 1'b1};
        vaddr = 32'h0000_9000;
        for (int i = 0; i < 4; i++) begin
            mode = f_mode[i]; tlb_hit = f_hit[i]; access_valid = f_valid[i]; flush = f_flush[i];
            settle();
            check($sformatf("filt%0d_now_busy", i), 32'(busy), 32'd0);
            tick();
            check_quiet($sformatf("filt%0d", i));
        end
        mode = USER; tlb_hit = 1'b0; access_valid = 1'b0; flush = 1'b0;
        tick();

        // Flush in the 2nd REQ cycle, mem_ready two cycles later
        access_valid = 1'b1; vaddr = 32'h0000_5ABC; ptbr = 32'h0001_0000;
        tick();
        check("fl_req1", 32'(mem_if.mem_req), 32'd1);
        tick();
        flush = 1'b1;
        settle();
        check("fl_req2", 32'(mem_if.mem_req), 32'd1);
        tick();
        flush = 1'b0; access_valid = 1'b0;
        settle();
        check("fl_drain_req", 32'(mem_if.mem_req), 32'd0);
        check("fl_drain_busy", 32'(busy), 32'd1);
        tick();
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h8000_0777;
        settle();
        check("fl_drain2_busy", 32'(busy), 32'd1);
        check("fl_drain2_wr", 32'(tlb_write), 32'd0);
        tick();
        mem_if.mem_ready = 1'b0;
        settle();
        check_quiet("fl_done");
        check("fl_pa_hold", tlb_paddr_new, 32'h0012_3000);
        tick();

        // Flush coincident with mem_ready
        access_valid = 1'b1;
        tick();
        access_valid = 1'b0; flush = 1'b1;
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h0000_0456;
        tick();
        flush = 1'b0; mem_if.mem_ready = 1'b0;
        settle();
        check_quiet("flc");
        check("flc_pa_hold", tlb_paddr_new, 32'h0012_3000);
        check("flc_fva_hold", fault_vaddr, 32'h0000_5ABC);
        tick();

        // PTE address wrap
        ptbr = 32'hFFFF_FFF0; vaddr = 32'h0000_8000; access_valid = 1'b1;
        tick();
        access_valid = 1'b0;
        check("wrap_addr", mem_if.mem_addr, 32'h0000_0010);
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h800A_BCDE;
        tick();
        mem_if.mem_ready = 1'b0;
        settle();
        check("wrap_wr", 32'(tlb_write), 32'd1);
        check("wrap_pa", tlb_paddr_new, 32'hABCD_E000);
        check("wrap_wva", walk_vaddr, 32'h0000_8000);
        tick();

        // Reset mid-walk; a late mem_ready is ignored
        ptbr = 32'h0001_0000; vaddr = 32'h0000_7000; access_valid = 1'b1;
        tick();
        check("rmw_addr", mem_if.mem_addr, 32'h0001_001C);
        check("rmw_req", 32'(mem_if.mem_req), 32'd1);
        reset = 1'b1; access_valid = 1'b0;
        tick();
        reset = 1'b0;
        settle();
        check_quiet("rmw");
        check("rmw_mem_addr", mem_if.mem_addr, 32'h0);
        check("rmw_wva", walk_vaddr, 32'h0);
        check("rmw_pa", tlb_paddr_new, 32'h0);
        check("rmw_fva", fault_vaddr, 32'h0);
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 32'h8000_0555;
        tick();
        mem_if.mem_ready = 1'b0;
        settle();
        check_quiet("rmw_late");
        check("rmw_late_pa", tlb_paddr_new, 32'h0);
        tick();
        check_quiet("rmw_late2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
